// File: rtl/microcpu_pkg.sv
// Shared types and constants for the micro-CPU memory subsystem.
package microcpu_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  // Command presented to the unified memory while m_req is high
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_timeout.sv
// Wait-cycle counter for an outstanding memory access; flags the cycle that
// would take the count to TIMEOUT without an acknowledge.
module mem_timeout
  import microcpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // This un-acked cycle is the one that brings the count to TIMEOUT
  assign expired_c = en && (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto a single-port unified
// memory; data wins over fetch, and stuck accesses are aborted after TIMEOUT.
module mem_arbiter
  import microcpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall,
  output logic              bus_err
);

  arb_state_e state_q, state_d;
  mem_cmd_t   cmd_q, cmd_d;
  logic       grant_c;
  logic       ack_c;
  logic       timeout_c;
  logic       done_c;
  logic       expired_c;
  logic       data_req_c;
  logic       pulse_c;

  assign data_req_c = d_rd | d_wr;
  assign pulse_c    = if_valid | d_valid;
  assign done_c     = ack_c | timeout_c;

  mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (grant_c),
    .en        (m_req & ~m_ack),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant only from IDLE outside a completion cycle; an ack beats a timeout
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    grant_c   = 1'b0;
    ack_c     = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!pulse_c) begin
          if (data_req_c) begin
            state_d     = ST_DATA;
            grant_c     = 1'b1;
            cmd_d.we    = d_wr;
            cmd_d.addr  = d_addr;
            cmd_d.wdata = d_wdata;
          end else if (if_req) begin
            state_d     = ST_FETCH;
            grant_c     = 1'b1;
            cmd_d.we    = 1'b0;
            cmd_d.addr  = if_addr;
            cmd_d.wdata = '0;
          end
        end
      end
      ST_FETCH, ST_DATA: begin
        if (m_req && m_ack) begin
          ack_c   = 1'b1;
          state_d = ST_IDLE;
        end else if (expired_c) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      m_req    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      bus_err  <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_c) begin
        m_req <= 1'b1;
      end else if (done_c) begin
        m_req <= 1'b0;
      end
      // Aborted accesses still complete, returning zero data
      if (done_c) begin
        if (state_q == ST_DATA) begin
          d_valid <= 1'b1;
          d_rdata <= ack_c ? m_rdata : '0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= ack_c ? m_rdata : '0;
        end
      end
      if (timeout_c) begin
        bus_err <= 1'b1;
      end
    end
  end

  assign m_we    = cmd_q.we;
  assign m_addr  = cmd_q.addr;
  assign m_wdata = cmd_q.wdata;

  assign stall = (state_q != ST_IDLE) | ((if_req | data_req_c) & ~if_valid & ~d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a configurable-latency memory responder.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ack = 1'b0;
  logic        stall;
  logic        bus_err;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 0;
  bit          mem_never = 1'b0;
  logic [31:0] mem_data = 32'h0;
  int          wait_cnt = 0;
  int          n_if = 0;
  int          n_d = 0;
  int          base;

  mem_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .stall    (stall),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks mem_lat cycles after m_req rises, unless mem_never
  always @(negedge clk) begin
    if (reset || !m_req) begin
      m_ack    = 1'b0;
      wait_cnt = 0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else begin
      if (!mem_never && wait_cnt == mem_lat) begin
        m_ack   = 1'b1;
        m_rdata = mem_data;
      end
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    if (if_valid) n_if++;
    if (d_valid)  n_d++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    cyc(3);
    check("rst_m_req",   32'(m_req), 32'd0);
    check("rst_m_addr",  m_addr, 32'h0);
    check("rst_if_vld",  32'(if_valid), 32'd0);
    check("rst_d_vld",   32'(d_valid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stall",   32'(stall), 32'd0);
    check("rst_if_rd",   if_rdata, 32'h0);
    reset = 1'b0;
    cyc(1);

    // Single fetch, ack two cycles after m_req
    mem_lat = 2; mem_data = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h10;
    #1 check("t1_stall_req", 32'(stall), 32'd1);
    cyc(1);
    check("t1_m_req",  32'(m_req), 32'd1);
    check("t1_m_addr", m_addr, 32'h10);
    check("t1_m_we",   32'(m_we), 32'd0);
    cyc(1); check("t1_m_req2", 32'(m_req), 32'd1);
    cyc(1); check("t1_m_req3", 32'(m_req), 32'd1);
    check("t1_no_vld", 32'(if_valid), 32'd0);
    cyc(1);
    check("t1_if_vld", 32'(if_valid), 32'd1);
    check("t1_if_rd",  if_rdata, 32'hDEADBEEF);
    check("t1_m_req0", 32'(m_req), 32'd0);
    check("t1_stall0", 32'(stall), 32'd0);
    if_req = 1'b0;
    cyc(1);
    check("t1_vld_end", 32'(if_valid), 32'd0);
    check("t1_stall_end", 32'(stall), 32'd0);

    // Conflict: data write wins, fetch after completion plus a gap
    mem_lat = 1; mem_data = 32'h0BADF00D;
    if_req = 1'b1; if_addr = 32'h40;
    d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
    cyc(1);
    check("t2_m_req",   32'(m_req), 32'd1);
    check("t2_m_we",    32'(m_we), 32'd1);
    check("t2_m_addr",  m_addr, 32'h200);
    check("t2_m_wdata", m_wdata, 32'h55);
    cyc(2);
    check("t2_d_vld",   32'(d_valid), 32'd1);
    check("t2_if_vld0", 32'(if_valid), 32'd0);
    check("t2_m_req0",  32'(m_req), 32'd0);
    d_wr = 1'b0;
    cyc(1);
    check("t2_gap", 32'(m_req), 32'd0);
    cyc(1);
    check("t2_f_req",   32'(m_req), 32'd1);
    check("t2_f_we",    32'(m_we), 32'd0);
    check("t2_f_addr",  m_addr, 32'h40);
    check("t2_f_wdata", m_wdata, 32'h0);
    cyc(2);
    check("t2_if_vld", 32'(if_valid), 32'd1);
    check("t2_if_rd",  if_rdata, 32'h0BADF00D);
    if_req = 1'b0;
    cyc(1);

    // Zero-wait memory, back-to-back fetches
    mem_lat = 0; mem_data = 32'h11111111;
    if_req = 1'b1; if_addr = 32'h100;
    cyc(1);
    check("t3_m_req",  32'(m_req), 32'd1);
    check("t3_m_addr", m_addr, 32'h100);
    cyc(1);
    check("t3_vld1",   32'(if_valid), 32'd1);
    check("t3_rd1",    if_rdata, 32'h11111111);
    if_addr = 32'h104; mem_data = 32'h22222222;
    cyc(1);
    check("t3_idle_vld", 32'(if_valid), 32'd0);
    check("t3_idle_req", 32'(m_req), 32'd0);
    cyc(1);
    check("t3_m_req2",  32'(m_req), 32'd1);
    check("t3_m_addr2", m_addr, 32'h104);
    cyc(1);
    check("t3_vld2", 32'(if_valid), 32'd1);
    check("t3_rd2",  if_rdata, 32'h22222222);
    if_req = 1'b0;
    cyc(1);

    // Ack lands in the same cycle the counter would expire
    mem_lat = 3; mem_data = 32'hCAFEF00D;
    d_rd = 1'b1; d_addr = 32'h20;
    cyc(1);
    check("t4_m_req", 32'(m_req), 32'd1);
    check("t4_m_we",  32'(m_we), 32'd0);
    cyc(3);
    check("t4_m_req4", 32'(m_req), 32'd1);
    cyc(1);
    check("t4_d_vld",   32'(d_valid), 32'd1);
    check("t4_d_rd",    d_rdata, 32'hCAFEF00D);
    check("t4_bus_err", 32'(bus_err), 32'd0);
    check("t4_m_req0",  32'(m_req), 32'd0);
    d_rd = 1'b0;
    cyc(1);

    // Timeout with a silent memory
    mem_never = 1'b1;
    d_rd = 1'b1; d_addr = 32'h300;
    cyc(1);
    check("t5_m_req1", 32'(m_req), 32'd1);
    cyc(3);
    check("t5_m_req4", 32'(m_req), 32'd1);
    check("t5_no_vld", 32'(d_valid), 32'd0);
    cyc(1);
    check("t5_m_req0", 32'(m_req), 32'd0);
    check("t5_d_vld",  32'(d_valid), 32'd1);
    check("t5_d_rd",   d_rdata, 32'h0);
    check("t5_err",    32'(bus_err), 32'd1);
    d_rd = 1'b0;
    cyc(1);
    check("t5_vld_end", 32'(d_valid), 32'd0);
    check("t5_err_hold", 32'(bus_err), 32'd1);
    mem_never = 1'b0; mem_lat = 0; mem_data = 32'h33;
    if_req = 1'b1; if_addr = 32'h8;
    cyc(2);
    check("t5_rec_vld", 32'(if_valid), 32'd1);
    check("t5_rec_rd",  if_rdata, 32'h33);
    check("t5_err_sticky", 32'(bus_err), 32'd1);
    if_req = 1'b0;
    cyc(1);

    // Reset in the middle of an access
    mem_never = 1'b1; base = n_if;
    if_req = 1'b1; if_addr = 32'h50;
    cyc(1);
    check("t6_m_req", 32'(m_req), 32'd1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("t6_m_req0",  32'(m_req), 32'd0);
    check("t6_if_vld",  32'(if_valid), 32'd0);
    check("t6_err_clr", 32'(bus_err), 32'd0);
    check("t6_m_addr",  m_addr, 32'h0);
    check("t6_stall",   32'(stall), 32'd1);
    reset = 1'b0; if_req = 1'b0; mem_never = 1'b0;
    cyc(1);
    check("t6_idle_req",   32'(m_req), 32'd0);
    check("t6_idle_stall", 32'(stall), 32'd0);
    cyc(2);
    check("t6_no_pulse", 32'(n_if - base), 32'd0);

    // Read and write together behave as a single write
    mem_lat = 1; mem_data = 32'h77; base = n_d;
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h8; d_wdata = 32'hA5A5A5A5;
    cyc(1);
    check("t7_m_we",    32'(m_we), 32'd1);
    check("t7_m_addr",  m_addr, 32'h8);
    check("t7_m_wdata", m_wdata, 32'hA5A5A5A5);
    cyc(2);
    check("t7_d_vld", 32'(d_valid), 32'd1);
    d_rd = 1'b0; d_wr = 1'b0;
    cyc(3);
    check("t7_one_pulse", 32'(n_d - base), 32'd1);

    // Requester drops early; access still completes
    mem_lat = 1; mem_data = 32'h99;
    d_rd = 1'b1; d_addr = 32'h44;
    cyc(1);
    check("t8_m_req", 32'(m_req), 32'd1);
    d_rd = 1'b0;
    #1 check("t8_stall", 32'(stall), 32'd1);
    cyc(2);
    check("t8_d_vld", 32'(d_valid), 32'd1);
    check("t8_d_rd",  d_rdata, 32'h99);
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
